// File: rtl/cia_pkg.sv
// Shared sizing helpers for the pipelined carry-increment adder.
// Functions: cia_nb (block count), cia_lat (stage count), cia_min.
package cia_pkg;

  function automatic int cia_nb(input int n, input int blk);
    return n / blk;
  endfunction

  function automatic int cia_lat(input int nb, input int bps);
    return (nb + bps - 1) / bps;
  endfunction

  function automatic int cia_min(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/cia_stage.sv
// One pipeline stage: resolves blocks K*BPS..min(NB,(K+1)*BPS)-1 of a
// carry-increment add and registers psum, carry, c_msb and remaining operand
// bits. Ports: in_* from previous stage (in_ready = advance), out_* registered.
module cia_stage
  import cia_pkg::*;
#(
  parameter int N   = 32,
  parameter int BLK = 4,
  parameter int BPS = 2,
  parameter int K   = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_psum,
  input  logic         in_carry,
  input  logic         in_c_msb,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_psum,
  output logic         out_carry,
  output logic         out_c_msb,
  output logic [N-1:0] out_a,
  output logic [N-1:0] out_b
);

  localparam int NB = cia_nb(N, BLK);
  localparam int LO = K * BPS;
  localparam int HI = cia_min(NB, LO + BPS);

  typedef struct packed {
    logic [N-1:0] psum;
    logic         carry;
    logic         c_msb;
    logic [N-1:0] a_rem;
    logic [N-1:0] b_rem;
    logic         valid;
  } stage_t;

  stage_t q;
  stage_t d;

  logic [N-1:0] psum_n;
  logic [N-1:0] a_n;
  logic [N-1:0] b_n;
  logic         c_msb_n;
  logic [NB:0]  cc;

  assign cc[0] = 1'b0;

  for (genvar b = 0; b < NB; b++) begin : g_blk
    if (b >= LO && b < HI) begin : g_own
      logic           ci;
      logic [BLK-1:0] ab;
      logic [BLK-1:0] bb;
      logic [BLK:0]   r;

      if (b == LO) begin : g_ci
        assign ci = in_carry;
      end else begin : g_ci
        assign ci = cc[b];
      end

      assign ab = in_a[b*BLK +: BLK];
      assign bb = in_b[b*BLK +: BLK];

      if (b == 0) begin : g_sum
        assign r = {1'b0, ab} + {1'b0, bb}
                 + {{BLK{1'b0}}, ci};
      end else begin : g_sum
        // both carry-in cases, selected late
        logic [BLK:0] r0;
        logic [BLK:0] r1;
        assign r0 = {1'b0, ab} + {1'b0, bb};
        assign r1 = r0 + 1'b1;
        assign r  = ci ? r1 : r0;
      end

      assign cc[b+1] = r[BLK];
      assign psum_n[b*BLK +: BLK] = r[BLK-1:0];
      assign a_n[b*BLK +: BLK] = '0;
      assign b_n[b*BLK +: BLK] = '0;

      if (b == NB - 1) begin : g_msb
        // sum bit = a ^ b ^ carry-in, so recover the carry into the MSB
        assign c_msb_n = r[BLK-1] ^ ab[BLK-1] ^ bb[BLK-1];
      end
    end else if (b < LO) begin : g_done
      assign cc[b+1] = 1'b0;
      assign psum_n[b*BLK +: BLK] = in_psum[b*BLK +: BLK];
      assign a_n[b*BLK +: BLK] = '0;
      assign b_n[b*BLK +: BLK] = '0;
    end else begin : g_todo
      assign cc[b+1] = 1'b0;
      assign psum_n[b*BLK +: BLK] = '0;
      assign a_n[b*BLK +: BLK] = in_a[b*BLK +: BLK];
      assign b_n[b*BLK +: BLK] = in_b[b*BLK +: BLK];
    end
  end

  if (HI != NB) begin : g_cm
    assign c_msb_n = in_c_msb;
  end

  // sink for input bits this stage never needs
  logic unused_bits;
  assign unused_bits = ^{in_psum, in_a, in_b, in_c_msb, cc};

  always_comb begin
    d       = '0;
    d.psum  = psum_n;
    d.carry = cc[HI];
    d.c_msb = c_msb_n;
    d.a_rem = a_n;
    d.b_rem = b_n;
    d.valid = in_valid;
  end

  assign in_ready = !q.valid || out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (in_ready) begin
      q <= d;
    end
  end

  assign out_valid = q.valid;
  assign out_psum  = q.psum;
  assign out_carry = q.carry;
  assign out_c_msb = q.c_msb;
  assign out_a     = q.a_rem;
  assign out_b     = q.b_rem;

endmodule

// File: rtl/pipelined_cia_adder.sv
// Pipelined carry-increment adder/subtractor, LAT stages, valid/ready both sides.
// Ports: in_valid/in_ready/in1/in2/cin/sub -> out_valid/out_ready/sum/cout/of.
// Define CIA_SATURATE_EN to clamp sum to signed max/min on overflow.
module pipelined_cia_adder
  import cia_pkg::*;
#(
  parameter int N   = 32,
  parameter int BLK = 4,
  parameter int BPS = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in1,
  input  logic [N-1:0] in2,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         of
);

  localparam int NB  = cia_nb(N, BLK);
  localparam int LAT = cia_lat(NB, BPS);

  logic         vld [0:LAT];
  logic         rdy [0:LAT];
  logic [N-1:0] ps  [0:LAT];
  logic         cy  [0:LAT];
  logic         cm  [0:LAT];
  logic [N-1:0] aa  [0:LAT];
  logic [N-1:0] bb  [0:LAT];

  assign vld[0]   = in_valid;
  assign ps[0]    = '0;
  assign cy[0]    = sub | cin;
  assign cm[0]    = 1'b0;
  assign aa[0]    = in1;
  assign bb[0]    = in2 ^ {N{sub}};
  assign rdy[LAT] = out_ready;

  for (genvar k = 0; k < LAT; k++) begin : g_stage
    cia_stage #(
      .N  (N),
      .BLK(BLK),
      .BPS(BPS),
      .K  (k)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (vld[k]),
      .in_ready (rdy[k]),
      .in_psum  (ps[k]),
      .in_carry (cy[k]),
      .in_c_msb (cm[k]),
      .in_a     (aa[k]),
      .in_b     (bb[k]),
      .out_valid(vld[k+1]),
      .out_ready(rdy[k+1]),
      .out_psum (ps[k+1]),
      .out_carry(cy[k+1]),
      .out_c_msb(cm[k+1]),
      .out_a    (aa[k+1]),
      .out_b    (bb[k+1])
    );
  end

  assign in_ready  = rdy[0];
  assign out_valid = vld[LAT];
  assign cout      = cy[LAT];
  assign of        = cm[LAT] ^ cy[LAT];

`ifdef CIA_SATURATE_EN
  // on overflow the wrapped sign is the inverse of in1's sign
  localparam logic [N-1:0] SMAX = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] SMIN = {1'b1, {(N-1){1'b0}}};
  assign sum = !of ? ps[LAT] :
               ps[LAT][N-1] ? SMAX : SMIN;
`else
  assign sum = ps[LAT];
`endif

  logic unused_rem;
  assign unused_rem = ^{aa[LAT], bb[LAT]};

endmodule

// File: tb/tb_pipelined_cia_adder.sv
// Scoreboard bench for pipelined_cia_adder (N=32, BLK=4, BPS=2, LAT=4).
// Directed corner cases, stall/reset scenarios, then random traffic.
module tb_pipelined_cia_adder;

  localparam int N   = 32;
  localparam int LAT = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] in1 = '0;
  logic [N-1:0] in2 = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [N-1:0] sum;
  logic         cout;
  logic         of;

  always #5 clk = ~clk;

  pipelined_cia_adder #(.N(N), .BLK(4), .BPS(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in1      (in1),
    .in2      (in2),
    .cin      (cin),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .of       (of)
  );

  typedef struct {
    logic [N-1:0] s;
    logic         c;
    logic         o;
    bit           lat;
    int           acc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   rdy_rand = 0;
  bit   rdy_hold = 0;
  bit   saw_stall = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : !rdy_hold;
  end

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [N-1:0] s,
                              input logic c, input logic o,
                              input bit lat);
    exp_t e;
    e.s = s; e.c = c; e.o = o; e.lat = lat; e.acc = 0;
    return e;
  endfunction

  // reference: plain arithmetic on N+1 bits, overflow from operand signs
  function automatic exp_t model(input logic [N-1:0] a,
                                 input logic [N-1:0] b,
                                 input logic c, input logic s);
    logic [N:0]   t;
    logic [N-1:0] bo;
    logic         ci;
    logic         o;
    logic [N-1:0] r;
    bo = s ? ~b : b;
    ci = s ? 1'b1 : c;
    t  = {1'b0, a} + {1'b0, bo} + {{N{1'b0}}, ci};
    o  = (a[N-1] == bo[N-1]) && (t[N-1] != a[N-1]);
    r  = t[N-1:0];
`ifdef CIA_SATURATE_EN
    if (o) r = a[N-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    return mk(r, t[N], o, 1'b0);
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_output actual=%0h required=none", sum);
      end else begin
        e = sb.pop_front();
        check("sum", sum, e.s);
        check("cout", cout, e.c);
        check("of", of, e.o);
        if (e.lat) check("latency_edge", cyc + 1, e.acc + LAT);
      end
    end
  end

  task automatic send(input logic [N-1:0] a, input logic [N-1:0] b,
                      input logic c, input logic s, input exp_t e);
    int guard;
    guard = 0;
    in1 = a; in2 = b; cin = c; sub = s; in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        e.acc = cyc + 1;
        sb.push_back(e);
        break;
      end
      if (!saw_stall) begin
        saw_stall = 1;
        check("inflight_at_stall", sb.size(), LAT);
      end
      guard++;
      if (guard > 200) begin
        checks++;
        failures++;
        $display("FAIL accept_timeout actual=busy required=ready");
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_rnd(input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic c, input logic s);
    send(a, b, c, s, model(a, b, c, s));
  endtask

  function automatic logic [N-1:0] pick();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return '1;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic drain();
    int g;
    g = 0;
    while (sb.size() != 0 && g < 500) begin
      @(posedge clk);
      g++;
    end
    #1;
    check("drain_empty", sb.size(), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_of", of, 0);
    check("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;

    send(32'h5, 32'h3, 1'b0, 1'b0, mk(32'h8, 1'b0, 1'b0, 1'b1));
`ifdef CIA_SATURATE_EN
    send(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0,
         mk(32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0));
`else
    send(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0,
         mk(32'h8000_0000, 1'b0, 1'b1, 1'b0));
`endif
    send(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, mk(32'h0, 1'b1, 1'b0, 1'b0));
    send(32'h5, 32'h7, 1'b1, 1'b1, mk(32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0));
    send(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0,
         mk(32'h2345_678A, 1'b0, 1'b0, 1'b0));
    drain();

    fork
      begin
        for (int i = 0; i < 10; i++)
          send_rnd($urandom, $urandom, 1'($urandom), 1'($urandom));
      end
      begin
        repeat (2) @(posedge clk);
        rdy_hold = 1;
        repeat (7) @(posedge clk);
        rdy_hold = 0;
      end
    join
    drain();
    check("stall_seen", saw_stall, 1);

    rdy_hold = 1;
    for (int i = 0; i < LAT; i++)
      send_rnd($urandom, $urandom, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_sum", sum, 0);
    check("midrst_cout", cout, 0);
    check("midrst_of", of, 0);
    sb.delete();
    rst_n = 1'b1;
    rdy_hold = 0;
    @(posedge clk); #1;
    send(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0,
         mk(32'h0000_0100, 1'b0, 1'b0, 1'b1));
    drain();

    rdy_rand = 1;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      send_rnd(pick(), pick(), 1'($urandom), 1'($urandom));
    end
    rdy_rand = 0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
